// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the 16-bit core decode stage.
//   Contents: opcode constants, the decoded-instruction record and its decode
//   function, the decode FSM state encoding and the forwarding-select encodings.
package isa_pkg;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LDI  = 4'h9;
   localparam logic [3:0] OP_LD   = 4'hA;
   localparam logic [3:0] OP_ST   = 4'hB;
   localparam logic [3:0] OP_BEQZ = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  dst;
      logic [3:0]  srca;
      logic [3:0]  srcb;
      logic [15:0] imm;
      logic        reg_wr;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jump;
      logic        jr;
   } dec_t;

   // {operand A used, operand B used}
   function automatic logic [1:0] src_use(input logic [3:0] op);
      return {op inside {[OP_ADD:OP_ADDI], OP_LD, OP_ST, OP_BEQZ, OP_JR},
              op inside {[OP_ADD:OP_SHR], OP_ST}};
   endfunction

   // Unused operand slots and the destination of non-writing ops carry 0.
   function automatic dec_t decode(input logic [3:0] op, input logic [3:0] rd,
                                   input logic [3:0] rs1, input logic [3:0] rs2,
                                   input logic [7:0] imm_off);
      logic [1:0] u;
      dec_t d;
      u        = src_use(op);
      d.op     = op;
      d.reg_wr = op inside {[OP_ADD:OP_LD]};
      d.dst    = d.reg_wr ? rd : 4'h0;
      d.srca   = !u[1] ? 4'h0 : (op == OP_ADDI || op == OP_BEQZ) ? rd : rs1;
      d.srcb   = !u[0] ? 4'h0 : (op == OP_ST) ? rd : rs2;
      d.imm    = (op inside {OP_ADDI, OP_BEQZ, OP_JMP}) ? {{8{imm_off[7]}}, imm_off} :
                 (op == OP_LDI) ? {8'h00, imm_off} : 16'h0000;
      d.mem_rd = op == OP_LD;
      d.mem_wr = op == OP_ST;
      d.branch = op == OP_BEQZ;
      d.jump   = op == OP_JMP;
      d.jr     = op == OP_JR;
      return d;
   endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: combinational match of ID source registers against EX/MEM destinations.
//   In : srca/srcb + use_a/use_b (ID sources), ex_valid/ex_reg_wr/ex_dst (EX stage),
//        ex_mem_rd (FWD_SEL_EN only), mem_dst/mem_wr (MEM stage)
//   Out: stall, fwd_a/fwd_b (FWD_SEL_EN only)
//   Macro FWD_SEL_EN: forward from EX/MEM and stall only on load-use;
//   otherwise stall on any EX or MEM match.
module hazard_detect_unit
   import isa_pkg::*;
(
   input  logic [3:0] srca,
   input  logic [3:0] srcb,
   input  logic       use_a,
   input  logic       use_b,
   input  logic       ex_valid,
   input  logic       ex_reg_wr,
`ifdef FWD_SEL_EN
   input  logic       ex_mem_rd,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
`endif
   input  logic [3:0] ex_dst,
   input  logic [3:0] mem_dst,
   input  logic       mem_wr,
   output logic       stall
);

   logic ex_a, ex_b, mem_a, mem_b;

   assign ex_a  = use_a && ex_valid && ex_reg_wr && srca == ex_dst;
   assign ex_b  = use_b && ex_valid && ex_reg_wr && srcb == ex_dst;
   assign mem_a = use_a && mem_wr && srca == mem_dst;
   assign mem_b = use_b && mem_wr && srcb == mem_dst;

`ifdef FWD_SEL_EN
   // A load's data is not ready until MEM finishes, so only that case stalls.
   assign stall = ex_mem_rd && (ex_a || ex_b);
   assign fwd_a = ex_a ? FWD_EX : mem_a ? FWD_MEM : FWD_RF;
   assign fwd_b = ex_b ? FWD_EX : mem_b ? FWD_MEM : FWD_RF;
`else
   assign stall = ex_a || ex_b || mem_a || mem_b;
`endif

endmodule

// File: rtl/inst_decode_unit.sv
// inst_decode_unit: decode stage; decodes IR fields into the ID/EX register,
//   stalls fetch on hazards, squashes wrong-path instructions, stops on HALT.
//   In : clk, rst_n (async, active-low), opcode/rd/rs1/rs2/imm_off (IR fields),
//        ex_br_taken, mem_dst/mem_wr (MEM-stage destination)
//   Out: pc_inc/ir_wr (to fetch), idex_* (ID/EX register), idex_fwd_a/b
//        (FWD_SEL_EN only), halted (sticky)
//   Macro FWD_SEL_EN: enables forwarding selects; default build stalls instead.
module inst_decode_unit
   import isa_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  opcode,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs1,
   input  logic [3:0]  rs2,
   input  logic [7:0]  imm_off,
   input  logic        ex_br_taken,
   input  logic [3:0]  mem_dst,
   input  logic        mem_wr,
   output logic        pc_inc,
   output logic        ir_wr,
   output logic        idex_valid,
   output logic [3:0]  idex_op,
   output logic [3:0]  idex_dst,
   output logic [3:0]  idex_srca,
   output logic [3:0]  idex_srcb,
   output logic [15:0] idex_imm,
   output logic        idex_reg_wr,
   output logic        idex_mem_rd,
   output logic        idex_mem_wr,
   output logic        idex_branch,
   output logic        idex_jump,
   output logic        idex_jr,
`ifdef FWD_SEL_EN
   output logic [1:0]  idex_fwd_a,
   output logic [1:0]  idex_fwd_b,
`endif
   output logic        halted
);

   state_t     state, state_nx;
   dec_t       d, ex;
   logic [1:0] u;
   logic       stall, bubble;

   assign d = decode(opcode, rd, rs1, rs2, imm_off);
   assign u = src_use(opcode);

`ifdef FWD_SEL_EN
   logic [1:0] fwd_a, fwd_b;
`endif

   hazard_detect_unit u_hdu (
      .srca      (d.srca),
      .srcb      (d.srcb),
      .use_a     (u[1]),
      .use_b     (u[0]),
      .ex_valid  (idex_valid),
      .ex_reg_wr (ex.reg_wr),
`ifdef FWD_SEL_EN
      .ex_mem_rd (ex.mem_rd),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
`endif
      .ex_dst    (ex.dst),
      .mem_dst   (mem_dst),
      .mem_wr    (mem_wr),
      .stall     (stall)
   );

   // Priority: HALT state, flush slot, taken branch, stall, HALT decode, normal.
   // A taken branch keeps fetch running so the target gets loaded.
   always_comb begin
      state_nx = state;
      bubble   = 1'b1;
      pc_inc   = 1'b1;
      if (state == ST_HALT)
         pc_inc = 1'b0;
      else if (state == ST_FLUSH)
         state_nx = ST_RUN;
      else if (ex_br_taken)
         state_nx = ST_FLUSH;
      else if (stall)
         pc_inc = 1'b0;
      else if (opcode == OP_HALT) begin
         state_nx = ST_HALT;
         pc_inc   = 1'b0;
      end else
         bubble = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         idex_valid <= 1'b0;
         ex         <= '0;
`ifdef FWD_SEL_EN
         idex_fwd_a <= FWD_RF;
         idex_fwd_b <= FWD_RF;
`endif
      end else begin
         state      <= state_nx;
         idex_valid <= !bubble;
         ex         <= bubble ? '0 : d;
`ifdef FWD_SEL_EN
         idex_fwd_a <= bubble ? FWD_RF : fwd_a;
         idex_fwd_b <= bubble ? FWD_RF : fwd_b;
`endif
      end
   end

   assign ir_wr       = pc_inc;
   assign halted      = state == ST_HALT;
   assign idex_op     = ex.op;
   assign idex_dst    = ex.dst;
   assign idex_srca   = ex.srca;
   assign idex_srcb   = ex.srcb;
   assign idex_imm    = ex.imm;
   assign idex_reg_wr = ex.reg_wr;
   assign idex_mem_rd = ex.mem_rd;
   assign idex_mem_wr = ex.mem_wr;
   assign idex_branch = ex.branch;
   assign idex_jump   = ex.jump;
   assign idex_jr     = ex.jr;

endmodule

// File: tb/tb_inst_decode_unit.sv
// tb_inst_decode_unit: self-checking bench for inst_decode_unit (default or FWD_SEL_EN build).
module tb_inst_decode_unit;

   typedef struct packed {
      logic        v;
      logic [3:0]  op, dst, a, b;
      logic [15:0] imm;
      logic        rw, mr, mw, br, jp, jr;
      logic [1:0]  fa, fb;
   } ex_t;

   logic        clk = 0, rst_n = 0;
   logic [3:0]  opcode = 0, rd = 0, rs1 = 0, rs2 = 0, mem_dst = 0;
   logic [7:0]  imm_off = 0;
   logic        ex_br_taken = 0, mem_wr = 0;
   logic        pc_inc, ir_wr, idex_valid, idex_reg_wr, idex_mem_rd, idex_mem_wr;
   logic        idex_branch, idex_jump, idex_jr, halted;
   logic [3:0]  idex_op, idex_dst, idex_srca, idex_srcb;
   logic [15:0] idex_imm;
   logic [1:0]  fa, fb;

   ex_t         m_ex = '0, m_nx;
   logic        m_st;
   logic [3:0]  mm_dst = 0;
   logic        mm_wr = 0, m_halt = 0, m_flush = 0;
   int          n_cmp = 0, n_bad = 0, n;

   always #5 clk = ~clk;

   inst_decode_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm_off(imm_off), .ex_br_taken(ex_br_taken), .mem_dst(mem_dst), .mem_wr(mem_wr),
      .pc_inc(pc_inc), .ir_wr(ir_wr), .idex_valid(idex_valid), .idex_op(idex_op),
      .idex_dst(idex_dst), .idex_srca(idex_srca), .idex_srcb(idex_srcb),
      .idex_imm(idex_imm), .idex_reg_wr(idex_reg_wr), .idex_mem_rd(idex_mem_rd),
      .idex_mem_wr(idex_mem_wr), .idex_branch(idex_branch), .idex_jump(idex_jump),
      .idex_jr(idex_jr),
`ifdef FWD_SEL_EN
      .idex_fwd_a(fa), .idex_fwd_b(fb),
`endif
      .halted(halted)
   );

`ifndef FWD_SEL_EN
   assign fa = 2'b00;
   assign fb = 2'b00;
`endif

   wire [42:0] dut_vec = {idex_valid, idex_op, idex_dst, idex_srca, idex_srcb, idex_imm,
                          idex_reg_wr, idex_mem_rd, idex_mem_wr, idex_branch, idex_jump,
                          idex_jr, fa, fb};

   // Instruction table straight from the ISA listing.
   function automatic ex_t dec(input logic [3:0] op, r_d, r_s1, r_s2, input logic [7:0] im,
                               output logic ua, output logic ub);
      ex_t e = '0;
      e.v = 1; e.op = op; ua = 0; ub = 0;
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                 begin e.dst = r_d; e.a = r_s1; e.b = r_s2; e.rw = 1; ua = 1; ub = 1; end
         4'h8: begin e.dst = r_d; e.a = r_d; e.imm = {{8{im[7]}}, im}; e.rw = 1; ua = 1; end
         4'h9: begin e.dst = r_d; e.imm = {8'h00, im}; e.rw = 1; end
         4'hA: begin e.dst = r_d; e.a = r_s1; e.rw = 1; e.mr = 1; ua = 1; end
         4'hB: begin e.a = r_s1; e.b = r_d; e.mw = 1; ua = 1; ub = 1; end
         4'hC: begin e.a = r_d; e.imm = {{8{im[7]}}, im}; e.br = 1; ua = 1; end
         4'hD: begin e.imm = {{8{im[7]}}, im}; e.jp = 1; end
         4'hE: begin e.a = r_s1; e.jr = 1; ua = 1; end
         default: ;
      endcase
      return e;
   endfunction

   // 1 = producer in EX, 2 = producer in MEM, 0 = none
   function automatic logic [1:0] src_hit(input logic used, input logic [3:0] r);
      if (!used) return 2'd0;
      if (m_ex.v && m_ex.rw && m_ex.dst == r) return 2'd1;
      if (mem_wr && mem_dst == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic model(output ex_t nx);
      logic ua, ub;
      logic [1:0] sa, sb;
      nx = dec(opcode, rd, rs1, rs2, imm_off, ua, ub);
      sa = src_hit(ua, nx.a);
      sb = src_hit(ub, nx.b);
`ifdef FWD_SEL_EN
      nx.fa = sa; nx.fb = sb;
      return m_ex.mr && (sa == 2'd1 || sb == 2'd1);
`else
      return sa != 2'd0 || sb != 2'd0;
`endif
   endfunction

   function automatic logic exp_pc();
      ex_t t;
      logic s;
      s = model(t);
      if (m_halt) return 0;
      if (m_flush || ex_br_taken) return 1;
      return !(s || opcode == 4'hF);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ex = '0; mm_dst = 0; mm_wr = 0; m_halt = 0; m_flush = 0;
      end else begin
         m_st = model(m_nx);
         mm_dst = m_ex.dst; mm_wr = m_ex.rw;
         if (m_halt) m_ex = '0;
         else if (m_flush) begin m_ex = '0; m_flush = 0; end
         else if (ex_br_taken) begin m_ex = '0; m_flush = 1; end
         else if (m_st) m_ex = '0;
         else if (opcode == 4'hF) begin m_ex = '0; m_halt = 1; end
         else m_ex = m_nx;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pc_inc", pc_inc, exp_pc());
      chk("ir_wr", ir_wr, exp_pc());
      chk("idex", dut_vec, m_ex);
      chk("halted", halted, m_halt);
   end

   task automatic drive(input logic [15:0] ir, input logic br = 0);
      {opcode, rd, rs1, rs2} = ir;
      imm_off = ir[7:0];
      ex_br_taken = br;
      mem_dst = mm_dst;
      mem_wr = mm_wr;
      #1;
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [15:0] ir, input logic br = 0);
      drive(ir, br);
      edge_();
   endtask

   task automatic stall_run(input logic [15:0] ir);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         drive(ir);
         if (pc_inc) break;
         n++;
         edge_();
      end
      edge_();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      drive(16'h0000);
      repeat (2) edge_();
      chk("rst_valid", idex_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc_inc", pc_inc, 1);
      rst_n = 1;
      step(16'h1123);
      chk("add_vec", {idex_valid, idex_op, idex_dst, idex_srca, idex_srcb, idex_reg_wr},
          {1'b1, 16'h1123, 1'b1});
      drive(16'h0000);
      chk("add_pc_inc", pc_inc, 1);
      repeat (3) step(16'h0000);

      step(16'hA450);
      stall_run(16'h1647);
`ifdef FWD_SEL_EN
      chk("lu_stalls", n, 1);
      chk("lu_fwd_a", fa, 2'b10);
`else
      chk("lu_stalls", n, 2);
`endif
      chk("lu_add", {idex_valid, idex_op, idex_dst, idex_srca, idex_srcb}, {1'b1, 16'h1647});
      repeat (3) step(16'h0000);

      step(16'h1123);
      stall_run(16'h2411);
`ifdef FWD_SEL_EN
      chk("raw_stalls", n, 0);
      chk("raw_fwd", {fa, fb}, 4'b0101);
`else
      chk("raw_stalls", n, 2);
`endif
      chk("raw_sub", {idex_op, idex_dst, idex_srca, idex_srcb}, 16'h2411);
      repeat (3) step(16'h0000);

      step(16'hA450);
      drive(16'h1647, 1);
      chk("br_pc_inc", pc_inc, 1);
      edge_();
      chk("br_bubble1", idex_valid, 0);
      drive(16'h3123);
      chk("flush_pc_inc", pc_inc, 1);
      edge_();
      chk("br_bubble2", idex_valid, 0);
      step(16'h4567);
      chk("br_resume", {idex_valid, idex_op}, 5'h14);
      repeat (3) step(16'h0000);

      step(16'h8AFE);
      chk("addi_imm", idex_imm, 16'hFFFE);
      chk("addi_srca", idex_srca, 4'hA);
      step(16'h9AFE);
      chk("ldi_imm", idex_imm, 16'h00FE);
      chk("ldi_srca", idex_srca, 0);
      step(16'hC3F0);
      step(16'hDFF0);
      chk("jmp_imm", idex_imm, 16'hFFF0);
      step(16'hE0A0);
      repeat (2) step(16'h0000);
      step(16'hB450);
      chk("st_ops", {idex_srca, idex_srcb, idex_mem_wr, idex_reg_wr}, 10'b0101_0100_10);
      repeat (2) step(16'h0000);

      drive(16'hF000);
      chk("halt_pc_inc", pc_inc, 0);
      edge_();
      chk("halted_set", halted, 1);
      for (int i = 0; i < 3; i++) begin
         drive(16'h1123, i == 1);
         chk("halt_hold_pc", pc_inc, 0);
         edge_();
         chk("halt_bubble", {halted, idex_valid}, 2'b10);
      end
      drive(16'h1123);
      rst_n = 0;
      #1;
      chk("rst_halted_clr", {halted, idex_valid, pc_inc}, 3'b001);
      rst_n = 1;
      edge_();
      step(16'h1123);
      chk("post_rst_run", {idex_valid, idex_op}, 5'h11);
      repeat (2) step(16'h0000);

      step(16'hA450);
      drive(16'h1647);
      chk("ms_stall", pc_inc, 0);
      rst_n = 0;
      #1;
      chk("ms_reset", {idex_valid, pc_inc}, 2'b01);
      rst_n = 1;
      edge_();
      repeat (2) step(16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_decode_unit.md
# inst_decode_unit

Decode stage of the pipelined 16-bit core, directly downstream of the instruction fetch unit. Each cycle it decodes the instruction register fields into control bits and loads them into the ID/EX pipeline register. It detects load-use and (optionally) RAW hazards, and back-pressures fetch by gating `pc_inc`/`ir_wr`. It squashes wrong-path instructions after a taken branch and stops fetch on HALT.

## Interface
- No parameters; widths fixed by the 16-bit ISA.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 4: IR[15:12].
- `rd` in 4: IR[11:8].
- `rs1` in 4: IR[7:4].
- `rs2` in 4: IR[3:0].
- `imm_off` in 8: IR[7:0].
- `ex_br_taken` in 1: EX resolved a taken BEQZ/JMP/JR this cycle; same cycle it drives `pc_load` to fetch.
- `mem_dst` in 4: destination register of the instruction now in MEM.
- `mem_wr` in 1: instruction in MEM writes `mem_dst`.
- `pc_inc` out 1: to fetch; advance PC.
- `ir_wr` out 1: to fetch; load IR.
- `idex_valid` out 1: EX holds a real instruction (0 = bubble).
- `idex_op` out 4: opcode.
- `idex_dst` out 4: destination register.
- `idex_srca` out 4: operand A register number.
- `idex_srcb` out 4: operand B register number.
- `idex_imm` out 16: extended immediate.
- `idex_reg_wr`, `idex_mem_rd`, `idex_mem_wr`, `idex_branch`, `idex_jump`, `idex_jr` out 1 each: control bits.
- `idex_fwd_a` out 2: forwarding select for operand A (only with FWD_SEL_EN).
- `idex_fwd_b` out 2: forwarding select for operand B (only with FWD_SEL_EN).
- `halted` out 1: sticky; HALT retired from ID.

## Operation
- Opcode map:
  - 0 NOP.
  - 1–7 ADD, SUB, AND, OR, XOR, SHL, SHR: rd←rs1 op rs2; A=rs1, B=rs2.
  - 8 ADDI: rd←rd+sext(imm); A=rd.
  - 9 LDI: rd←zext(imm).
  - A LD: rd←mem[rs1]; A=rs1.
  - B ST: mem[rs1]←rd; A=rs1, B=rd.
  - C BEQZ: if rd==0, PC+=sext(imm); A=rd.
  - D JMP: PC+=sext(imm).
  - E JR: PC←rs1; A=rs1.
  - F HALT.
- Unused operand slots carry 0 and are never hazard-checked.
- `idex_reg_wr` is set for opcodes 1–A.
- `idex_imm`:
  - sext(imm_off) for 8, C, D.
  - zext for 9.
  - 0 otherwise.
- All 16 registers, including r0, are ordinary and hazard-checked.
- FSM, three states:
  - RUN: normal decode.
    - `ex_br_taken` → FLUSH.
    - Unstalled HALT decoded → HALT.
  - FLUSH: the instruction arriving in IR is wrong-path. Insert a bubble, keep `pc_inc`/`ir_wr`=1, → RUN.
  - HALT: `pc_inc`=`ir_wr`=0, bubble every cycle, `halted`=1. Exit only via reset.
- Stall (RUN only):
  - Trigger: `idex_valid`, `idex_mem_rd`, and `idex_dst` matches a used source of the ID instruction.
  - Effect: `pc_inc`=`ir_wr`=0 and a bubble (all `idex_*` control 0, `idex_valid`=0).
- Taken branch: `ex_br_taken` squashes the ID instruction (bubble) regardless of stall or HALT. Penalty is 2 bubbles.
- Priority: `ex_br_taken` > stall > HALT > normal.

## Timing
- Reset values:
  - State RUN.
  - All `idex_*` 0 (`idex_valid`=0).
  - `halted`=0.
  - `pc_inc`=`ir_wr`=1, combinational from state/hazard.
- IR resets to 0 (NOP), so the first decode is a harmless bubble-equivalent.
- Decode-to-EX latency: 1 cycle. `idex_*` update every edge.
- Load-use stall lasts exactly 1 cycle; the stalled instruction re-decodes the next cycle.
- `halted` asserts the cycle after HALT is in ID and stays high. Instructions already in EX/MEM drain normally.
- Reset mid-stall or mid-flush returns to RUN with a bubble in EX.

## Configuration
- `FWD_SEL_EN` defined:
  - Only load-use stalls.
  - `idex_fwd_a`/`idex_fwd_b` are registered with the instruction. Encoding:
    - 01: operand matches the instruction currently in EX with `idex_reg_wr` set, which will be in MEM.
    - 10: otherwise, operand matches `mem_dst` with `mem_wr`, which will be in WB.
    - 00: register file.
  - EX-stage match has priority over MEM-stage match.
- `FWD_SEL_EN` undefined:
  - No fwd ports.
  - Stall whenever a used source matches `idex_dst` (valid, reg_wr) or `mem_dst` (`mem_wr`).
  - The register file is write-through, so WB never stalls.

## Structure
- Shared package `isa_pkg`: opcode constants, FSM state encoding, FWD_* select encodings.
- Sub-module `hazard_detect_unit`: combinational match of ID sources against EX/MEM destinations. Outputs `stall` and the fwd selects.

## Test plan
- Reset, IR=0x1123 (ADD r1,r2,r3) → next cycle `idex_valid`=1, op=1, dst=1, A=2, B=3, `reg_wr`=1; `pc_inc`=1.
- LD r4,[r5] then ADD r6,r4,r7:
  - Exactly 1 cycle with `pc_inc`=`ir_wr`=0 and a bubble.
  - Then ADD in EX with `idex_fwd_a`=10 (`FWD_SEL_EN`).
- ADD r1,r2,r3 then SUB r4,r1,r1 → no stall, `idex_fwd_a`=`idex_fwd_b`=01; without `FWD_SEL_EN`, 2 stall cycles.
- `ex_br_taken`=1 with a stalled instruction in ID → 2 consecutive bubbles, no stall cycle, back to RUN.
- IR=0xF000 → `halted`=1 next cycle; `pc_inc`=0 forever. `rst_n` pulse → `halted`=0, RUN.
- IR=0x8AFE (ADDI r10,-2) → `idex_imm`=0xFFFE. IR=0x9AFE → `idex_imm`=0x00FE.
